pcm_fetch: RTL and testbench

Playback prefetch stage between the SRAM Wishbone controller and the I2S transmitter. It reads 16-bit stereo PCM bytes from SRAM, assembles them into left/right frames and buffers them in a small FIFO. It presents one frame per codec word-clock period, so SRAM latency never stalls the DAC. The sequencing FSM in the top level starts and stops it; the I2S transmitter consumes `left_o`/`right_o`.

---
 rtl/pcm_fetch.sv | 166 ++++++++++++++++
 tb/tb_pcm_fetch.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_fetch.sv
// pcm_fetch: prefetches 16-bit stereo PCM frames from byte-wide SRAM over
// Wishbone into a small FIFO and presents one frame per codec word-clock period.
module pcm_fetch #(
   parameter int ADDR_W     = 19,
   parameter int FIFO_AW    = 2,
   parameter int START_ADDR = 44
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic                loop_i,
   input  logic [ADDR_W-1:0]   end_addr_i,
   input  logic                wclk_i,
   output logic                wb_cyc_o,
   output logic                wb_we_o,
   output logic [ADDR_W-1:0]   wb_adr_o,
   input  logic [7:0]          wb_dat_i,
   input  logic                wb_ack_i,
   output logic [15:0]         left_o,
   output logic [15:0]         right_o,
   output logic                busy_o,
   output logic                underrun_o,
   output logic [FIFO_AW:0]    level_o
);

   typedef enum logic [2:0] {IDLE, REQ, ACK, GAP, PUSH} state_t;

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [ADDR_W:0] FIRST_END = (ADDR_W+1)'(START_ADDR + 4);

   state_t               state;
   logic [ADDR_W-1:0]    addr;
   logic [ADDR_W-1:0]    end_latched;
   logic [3:0][7:0]      slots;
   logic [2:0]           byte_cnt;
   logic                 discard;
   logic [31:0]          fifo_mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic                 wclk_s1, wclk_s2, wclk_d;

   logic rise, empty, full, past_end, no_data, fetch_done, push, pop;

   assign wb_we_o    = 1'b0;
   assign rise       = wclk_s2 & ~wclk_d;
   assign empty      = (level_o == '0);
   assign full       = (level_o == (FIFO_AW+1)'(DEPTH));
   assign past_end   = ({1'b0, addr} + (ADDR_W+1)'(4)) > {1'b0, end_latched};
   assign no_data    = {1'b0, end_latched} < FIRST_END;
   assign fetch_done = (state == IDLE) && past_end && !loop_i;
   assign push       = (state == PUSH);
   assign pop        = rise && busy_o && !empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wclk_s1 <= 1'b0;
         wclk_s2 <= 1'b0;
         wclk_d  <= 1'b0;
      end else begin
         wclk_s1 <= wclk_i;
         wclk_s2 <= wclk_s1;
         wclk_d  <= wclk_s2;
      end
   end

   // NOTE: FIFO storage has no reset; level_o alone decides which entries are valid.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= slots;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         addr        <= '0;
         end_latched <= '0;
         slots       <= '0;
         byte_cnt    <= '0;
         discard     <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_adr_o    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_o     <= '0;
         left_o      <= '0;
         right_o     <= '0;
         busy_o      <= 1'b0;
         underrun_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (busy_o) begin
               if (no_data) busy_o <= 1'b0;
               else if (past_end) begin
                  if (loop_i) addr <= ADDR_W'(START_ADDR);
               end else if (!full) state <= REQ;
            end
            REQ: begin
               wb_cyc_o <= 1'b1;
               wb_adr_o <= addr;
               state    <= ACK;
            end
            ACK: if (wb_ack_i) begin
               wb_cyc_o <= 1'b0;
               if (discard) begin
                  discard <= 1'b0;
                  state   <= IDLE;
               end else begin
                  slots[addr[1:0]] <= wb_dat_i;
                  addr     <= addr + 1'b1;
                  byte_cnt <= byte_cnt + 1'b1;
                  state    <= GAP;
               end
            end
            GAP:  state <= (byte_cnt == 3'd4) ? PUSH : REQ;
            PUSH: begin
               byte_cnt <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level_o <= level_o + 1'b1;
         else if (pop && !push) level_o <= level_o - 1'b1;

         if (rise && busy_o) begin
            if (!empty) begin
               left_o  <= fifo_mem[rd_ptr][15:0];
               right_o <= fifo_mem[rd_ptr][31:16];
            end else begin
               left_o     <= '0;
               right_o    <= '0;
               underrun_o <= 1'b1;
               if (fetch_done) busy_o <= 1'b0;
            end
         end

         // NOTE: start/stop come last so their assignments override everything above.
         if (start_i || stop_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_o  <= '0;
            byte_cnt <= '0;
            if (state == ACK && !wb_ack_i) begin
               discard <= 1'b1;
            end else begin
               discard  <= 1'b0;
               wb_cyc_o <= 1'b0;
               state    <= IDLE;
            end
            if (stop_i) begin
               busy_o  <= 1'b0;
               left_o  <= '0;
               right_o <= '0;
            end else begin
               busy_o      <= 1'b1;
               underrun_o  <= 1'b0;
               end_latched <= end_addr_i;
               addr        <= ADDR_W'(START_ADDR);
            end
         end
      end
   end

endmodule

// File: tb/tb_pcm_fetch.sv
// Self-checking bench for pcm_fetch: SRAM model with variable ack latency,
// table-driven playback scenarios, hand-written corner cases and a random sweep.
module tb_pcm_fetch;
   localparam int START = 44;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, stop, loop_en, wclk, wb_ack;
   logic [18:0] end_addr;
   logic [7:0]  wb_dat;
   logic        wb_cyc, wb_we;
   logic [18:0] wb_adr;
   logic [15:0] left, right;
   logic        busy, underrun;
   logic [2:0]  level;

   pcm_fetch dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .loop_i(loop_en),
      .end_addr_i(end_addr), .wclk_i(wclk), .wb_cyc_o(wb_cyc), .wb_we_o(wb_we),
      .wb_adr_o(wb_adr), .wb_dat_i(wb_dat), .wb_ack_i(wb_ack), .left_o(left),
      .right_o(right), .busy_o(busy), .underrun_o(underrun), .level_o(level)
   );

   int checks = 0;
   int failures = 0;
   logic [7:0] sram [2048];
   int adr_log[$];
   int lat_lo = 1, lat_hi = 1;
   int adr_jumps = 0, we_high = 0;

   typedef struct {
      int          end_a;
      logic        lp;
      logic        busy;
      int          level;
      int          bytes;
      logic [31:0] frame;
      logic        und;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Byte-wide SRAM answering each request after a random number of wait cycles.
   initial begin : sram_model
      int wait_cnt = 0;
      int lat = 0;
      bit counting = 0;
      logic prev_cyc = 1'b0;
      logic [18:0] prev_adr = '0;
      wb_ack = 1'b0;
      wb_dat = '0;
      forever begin
         @(posedge clk); #1;
         if (wb_cyc && prev_cyc && wb_adr !== prev_adr) adr_jumps++;
         if (wb_we !== 1'b0) we_high++;
         prev_cyc = wb_cyc;
         prev_adr = wb_adr;
         if (wb_ack) wb_ack = 1'b0;
         else if (wb_cyc) begin
            if (!counting) begin
               counting = 1;
               wait_cnt = 0;
               lat = $urandom_range(lat_hi, lat_lo);
            end
            if (wait_cnt >= lat) begin
               wb_ack = 1'b1;
               wb_dat = sram[wb_adr[10:0]];
               adr_log.push_back(int'(wb_adr));
               counting = 0;
            end else wait_cnt++;
         end else counting = 0;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input int ea, input logic lp);
      end_addr = 19'(ea);
      loop_en  = lp;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_cyc(input logic want, input int budget, input string name);
      int n = 0;
      while (wb_cyc !== want && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, wb_cyc, want);
   endtask

   task automatic quiesce();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_cyc(1'b0, 40, "quiesce_cyc_low");
      tick(3);
      adr_log.delete();
   endtask

   task automatic do_edge();
      wclk = 1'b1;
      tick(3);
      wclk = 1'b0;
   endtask

   function automatic logic [31:0] frame_at(input int f);
      int b = START + 4 * f;
      return {sram[b+1], sram[b], sram[b+3], sram[b+2]};
   endfunction

   function automatic int seq_errors(input int nframes);
      int bad = 0;
      int sz = adr_log.size();
      for (int i = 0; i < sz; i++)
         if (adr_log[i] != START + (i % (4 * nframes))) bad++;
      return bad;
   endfunction

   initial begin : main
      int k, lp, ea, edges, exp_lvl, n;
      logic [31:0] exp_f;

      rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; wclk = 1'b0; end_addr = '0;
      for (int i = 0; i < 2048; i++) sram[i] = 8'(i * 37 + 11);
      sram[44] = 8'h34; sram[45] = 8'h12; sram[46] = 8'h78; sram[47] = 8'h56;
      sram[48] = 8'hCD; sram[49] = 8'hAB; sram[50] = 8'h01; sram[51] = 8'hEF;

      //            end   lp    busy  lvl bytes frame          und
      vecs[0] = '{52,   1'b0, 1'b1, 2,  8,    32'h1234_5678, 1'b0};
      vecs[1] = '{47,   1'b0, 1'b0, 0,  0,    32'h0,         1'b0};
      vecs[2] = '{48,   1'b0, 1'b1, 1,  4,    32'h1234_5678, 1'b0};
      vecs[3] = '{51,   1'b0, 1'b1, 1,  4,    32'h1234_5678, 1'b0};
      vecs[4] = '{54,   1'b1, 1'b1, 4,  16,   32'h1234_5678, 1'b0};
      vecs[5] = '{1044, 1'b0, 1'b1, 4,  16,   32'h1234_5678, 1'b0};
      vecs[6] = '{44,   1'b1, 1'b0, 0,  0,    32'h0,         1'b0};
      vecs[7] = '{52,   1'b1, 1'b1, 4,  16,   32'h1234_5678, 1'b0};

      // Reset values
      tick(3);
      check("rst_cyc", wb_cyc, 0);
      check("rst_adr", wb_adr, 0);
      check("rst_out", {left, right}, 0);
      check("rst_flags", {busy, underrun}, 0);
      check("rst_level", level, 0);
      rst = 1'b0;
      tick(3);
      check("idle_after_rst", {busy, wb_cyc}, 0);

      // Two frames with a 2-cycle ack: request timing, output latency, underrun
      pulse_start(52, 1'b0);
      check("start_busy", busy, 1);
      check("cyc_low_at_1", wb_cyc, 0);
      tick(1);
      check("cyc_low_in_req", wb_cyc, 0);
      tick(1);
      check("cyc_high_at_2", wb_cyc, 1);
      check("first_adr", wb_adr, START);
      tick(100);
      check("two_frames_level", level, 2);
      check("two_frames_idle", wb_cyc, 0);
      wclk = 1'b1;
      tick(2);
      check("out_not_early", {left, right}, 0);
      tick(1);
      check("frame0", {left, right}, 32'h1234_5678);
      check("level_after_pop", level, 1);
      wclk = 1'b0;
      tick(8);
      do_edge();
      check("frame1", {left, right}, 32'hABCD_EF01);
      check("busy_last_frame", busy, 1);
      tick(8);
      do_edge();
      check("underrun_out", {left, right}, 0);
      check("underrun_flag", underrun, 1);
      check("busy_falls", busy, 0);

      // Empty range: busy only for the start cycle
      quiesce();
      pulse_start(47, 1'b0);
      check("short_busy_pulse", busy, 1);
      tick(1);
      check("short_busy_low", busy, 0);
      check("short_no_cyc", wb_cyc, 0);

      // Table-driven playback scenarios on the fixed SRAM image
      for (int v = 0; v < 8; v++) begin
         quiesce();
         pulse_start(vecs[v].end_a, vecs[v].lp);
         tick(200);
         check($sformatf("v%0d_busy", v), busy, vecs[v].busy);
         check($sformatf("v%0d_level", v), level, vecs[v].level);
         check($sformatf("v%0d_bytes", v), adr_log.size(), vecs[v].bytes);
         check($sformatf("v%0d_cyc_idle", v), wb_cyc, 0);
         n = (vecs[v].end_a - START) / 4;
         if (vecs[v].end_a >= START + 4)
            check($sformatf("v%0d_adr_seq", v), seq_errors(n), 0);
         do_edge();
         check($sformatf("v%0d_frame", v), {left, right}, vecs[v].frame);
         check($sformatf("v%0d_underrun", v), underrun, vecs[v].und);
      end

      // stop and start together while a read is outstanding
      quiesce();
      lat_lo = 6; lat_hi = 6;
      pulse_start(1044, 1'b0);
      tick(250);
      do_edge();
      check("abort_pre_frame", {left, right}, 32'h1234_5678);
      wait_cyc(1'b1, 60, "abort_refetch_cyc");
      stop = 1'b1; start = 1'b1; end_addr = 19'd1044;
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
      check("abort_cyc_held", wb_cyc, 1);
      wait_cyc(1'b0, 20, "abort_ack_done");
      check("abort_busy", busy, 0);
      check("abort_level", level, 0);
      check("abort_out", {left, right}, 0);
      tick(20);
      check("abort_no_restart", {wb_cyc, busy}, 0);

      // Restart while a read is outstanding: that byte is discarded
      quiesce();
      lat_lo = 4; lat_hi = 4;
      pulse_start(1044, 1'b0);
      n = 0;
      while (adr_log.size() < 2 && n < 200) begin
         tick(1);
         n++;
      end
      check("restart_progress", adr_log.size() >= 2, 1);
      wait_cyc(1'b0, 20, "restart_gap");
      wait_cyc(1'b1, 20, "restart_third_req");
      pulse_start(52, 1'b0);
      tick(150);
      check("restart_level", level, 2);
      do_edge();
      check("restart_frame0", {left, right}, 32'h1234_5678);
      tick(8);
      do_edge();
      check("restart_frame1", {left, right}, 32'hABCD_EF01);

      // Asynchronous reset mid-cycle with three frames buffered
      quiesce();
      lat_lo = 1; lat_hi = 1;
      pulse_start(1044, 1'b0);
      tick(120);
      check("prereset_full", level, 4);
      do_edge();
      wait_cyc(1'b1, 20, "prereset_refill_req");
      check("prereset_three", level, 3);
      #2 rst = 1'b1;
      #1;
      check("arst_cyc", wb_cyc, 0);
      check("arst_out", {left, right}, 0);
      check("arst_flags", {busy, underrun}, 0);
      check("arst_level", level, 0);
      @(negedge clk);
      rst = 1'b0;
      tick(10);
      check("arst_stays_idle", {wb_cyc, busy}, 0);

      // Random sweep against a frame-stream model
      lat_lo = 0; lat_hi = 3;
      for (int it = 0; it < 6; it++) begin
         quiesce();
         for (int a = START; a < START + 40; a++) sram[a] = 8'($urandom);
         k  = $urandom_range(8, 1);
         lp = $urandom_range(1, 0);
         ea = START + 4 * k + $urandom_range(3, 0);
         pulse_start(ea, lp[0]);
         tick(150);
         edges = lp ? 6 : k + 1;
         for (int j = 0; j < edges; j++) begin
            exp_lvl = lp ? 4 : ((k - j) < 4 ? (k - j) : 4);
            check($sformatf("r%0d_e%0d_level", it, j), level, exp_lvl);
            do_edge();
            if (lp || j < k) begin
               exp_f = frame_at(lp ? j % k : j);
               check($sformatf("r%0d_e%0d_frame", it, j), {left, right}, exp_f);
               check($sformatf("r%0d_e%0d_flags", it, j), {busy, underrun}, 2'b10);
            end else begin
               check($sformatf("r%0d_e%0d_frame", it, j), {left, right}, 0);
               check($sformatf("r%0d_e%0d_flags", it, j), {busy, underrun}, 2'b01);
            end
            tick($urandom_range(80, 40));
         end
         check($sformatf("r%0d_adr_seq", it), seq_errors(k), 0);
         if (!lp) check($sformatf("r%0d_bytes", it), adr_log.size(), 4 * k);
      end

      check("adr_stable_in_cycle", adr_jumps, 0);
      check("we_always_low", we_high, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
